// File: rtl/matvec_ctrl_if.sv
// rtl/matvec_ctrl_if.sv - operand stream and MAC control bundle for matvec_ctrl
interface matvec_ctrl_if #(
  parameter int WIDTH = 12
);
  logic signed [WIDTH-1:0] input_data;
  logic                    input_valid;
  logic                    input_ready;
  logic signed [WIDTH-1:0] m_out;
  logic signed [WIDTH-1:0] v_out;
  logic                    clear_acc;
  logic                    en_acc;
  logic                    output_valid;
  logic                    output_ready;

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, m_out, v_out, clear_acc, en_acc, output_valid
  );

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, m_out, v_out, clear_acc, en_acc, output_valid
  );
endinterface

// File: rtl/matvec_ctrl.sv
// rtl/matvec_ctrl.sv - loads an MxN matrix and N-vector, then sequences one MAC row at a time
module matvec_ctrl #(
  parameter int WIDTH = 12,
  parameter int M     = 4,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         reset,
  matvec_ctrl_if.slave bus
);
  localparam int CW = $clog2(M * N + 1);
  localparam int AW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int VW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = $clog2(N + 1);

  typedef enum logic [2:0] {LOAD_M, LOAD_V, CLEAR, COMPUTE, OUTPUT} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           ld_cnt, ld_cnt_nxt;
  logic [RW-1:0]           row, row_nxt;
  logic [JW-1:0]           col, col_nxt;
  logic signed [WIDTH-1:0] mat [M*N];
  logic signed [WIDTH-1:0] vec [N];
  logic                    accept;
  logic [AW-1:0]           rd_idx;
  logic [VW-1:0]           v_idx;
  logic                    input_ready;
  logic                    clear_acc;
  logic                    en_acc;
  logic                    output_valid;
  logic signed [WIDTH-1:0] m_out;
  logic signed [WIDTH-1:0] v_out;

  // Matrix is stored flat; flat index k is row k/N, column k%N.
  assign rd_idx = AW'(int'(row) * N + int'(col));
  assign v_idx  = VW'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD_M;
      ld_cnt <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
      row    <= row_nxt;
      col    <= col_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == LOAD_M) begin
        mat[AW'(ld_cnt)] <= bus.input_data;
      end else begin
        vec[VW'(ld_cnt)] <= bus.input_data;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_cnt_nxt   = ld_cnt;
    row_nxt      = row;
    col_nxt      = col;
    accept       = 1'b0;
    input_ready  = 1'b0;
    clear_acc    = 1'b0;
    en_acc       = 1'b0;
    output_valid = 1'b0;
    m_out        = '0;
    v_out        = '0;
    case (state)
      LOAD_M: begin
        input_ready = 1'b1;
        accept      = bus.input_valid;
        if (accept) begin
          if (ld_cnt == CW'(M * N - 1)) begin
            state_nxt  = LOAD_V;
            ld_cnt_nxt = '0;
          end else begin
            ld_cnt_nxt = ld_cnt + 1'b1;
          end
        end
      end
      LOAD_V: begin
        input_ready = 1'b1;
        accept      = bus.input_valid;
        if (accept) begin
          if (ld_cnt == CW'(N - 1)) begin
            state_nxt  = CLEAR;
            ld_cnt_nxt = '0;
            row_nxt    = '0;
          end else begin
            ld_cnt_nxt = ld_cnt + 1'b1;
          end
        end
      end
      CLEAR: begin
        clear_acc = 1'b1;
        col_nxt   = '0;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        en_acc = 1'b1;
        // Column N is the flush cycle: zero operands push the sum into the lagged output register.
        if (col < JW'(N)) begin
          m_out = mat[rd_idx];
          v_out = vec[v_idx];
        end
        if (col == JW'(N)) begin
          state_nxt = OUTPUT;
        end else begin
          col_nxt = col + 1'b1;
        end
      end
      OUTPUT: begin
        output_valid = 1'b1;
        if (bus.output_ready) begin
          if (row == RW'(M - 1)) begin
            state_nxt  = LOAD_M;
            ld_cnt_nxt = '0;
          end else begin
            row_nxt   = row + 1'b1;
            state_nxt = CLEAR;
          end
        end
      end
      default: begin
        state_nxt = LOAD_M;
      end
    endcase
    // Outputs are forced quiet for the whole time reset is high, not just after the edge.
    if (reset) begin
      accept       = 1'b0;
      input_ready  = 1'b0;
      clear_acc    = 1'b0;
      en_acc       = 1'b0;
      output_valid = 1'b0;
      m_out        = '0;
      v_out        = '0;
    end
  end

  assign bus.input_ready  = input_ready;
  assign bus.clear_acc    = clear_acc;
  assign bus.en_acc       = en_acc;
  assign bus.output_valid = output_valid;
  assign bus.m_out        = m_out;
  assign bus.v_out        = v_out;
endmodule

// File: tb/tb_matvec_ctrl.sv
// tb/tb_matvec_ctrl.sv - directed bench for matvec_ctrl with a saturating MAC datapath model
module tb_matvec_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic signed [11:0] ref_m [16];
  logic signed [11:0] ref_v [4];
  logic signed [31:0] acc;
  logic signed [11:0] out_data;

  matvec_ctrl_if #(.WIDTH(12)) bus ();

  matvec_ctrl #(.WIDTH(12), .M(4), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] sat12(input logic signed [31:0] x);
    if (x > 32'sd2047) return 32'sd2047;
    if (x < -32'sd2048) return -32'sd2048;
    return x;
  endfunction

  // Datapath: saturating accumulator plus an output register lagging it by one enabled cycle.
  always @(posedge clk) begin
    if (reset) begin
      acc      <= 0;
      out_data <= 0;
    end else begin
      if (bus.clear_acc) acc <= 0;
      else if (bus.en_acc) acc <= sat12(acc + bus.m_out * bus.v_out);
      if (bus.en_acc) out_data <= acc[11:0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int k = 0; k < 16; k++) ref_m[k] = (k / 4 == k % 4) ? 12'sd1 : 12'sd0;
    ref_v[0] = 12'sd3; ref_v[1] = -12'sd2; ref_v[2] = 12'sd5; ref_v[3] = 12'sd7;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 16; k++) ref_m[k] = 12'(k + 1);
    for (int j = 0; j < 4; j++) ref_v[j] = 12'(j + 1);
  endtask

  task automatic load(input bit stall);
    for (int k = 0; k < 20; k++) begin
      if (stall && k > 0) begin
        bus.input_valid = 1'b0;
        bus.input_data  = 12'sh5A5;
        step();
      end
      bus.input_valid = 1'b1;
      bus.input_data  = (k < 16) ? ref_m[k] : ref_v[k-16];
      checks++;
      if (bus.input_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word %0d: got %b want 1", k, bus.input_ready);
      end
      step();
    end
    bus.input_valid = 1'b0;
    checks++;
    if (bus.input_ready !== 1'b0 || bus.clear_acc !== 1'b1) begin
      errors++;
      $display("FAIL load_done: ready %b clear_acc %b want 0 1", bus.input_ready, bus.clear_acc);
    end
  endtask

  task automatic run_row(input int row, input logic signed [11:0] exp, input int hold, input bit noise);
    checks++;
    if (bus.clear_acc !== 1'b1 || bus.en_acc !== 1'b0 || bus.input_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_state row %0d: clear %b en %b ready %b want 1 0 0",
               row, bus.clear_acc, bus.en_acc, bus.input_ready);
    end
    if (noise) begin
      bus.input_valid  = 1'b1;
      bus.input_data   = -12'sd5;
      bus.output_ready = 1'b1;
    end
    step();
    for (int c = 0; c <= 4; c++) begin
      logic signed [11:0] em;
      logic signed [11:0] ev;
      em = (c < 4) ? ref_m[row*4+c] : 12'sd0;
      ev = (c < 4) ? ref_v[c] : 12'sd0;
      checks++;
      if (bus.en_acc !== 1'b1 || bus.clear_acc !== 1'b0 || bus.output_valid !== 1'b0 ||
          bus.m_out !== em || bus.v_out !== ev) begin
        errors++;
        $display("FAIL compute row %0d cyc %0d: en %b clr %b ov %b m %0d v %0d want 1 0 0 %0d %0d",
                 row, c, bus.en_acc, bus.clear_acc, bus.output_valid, bus.m_out, bus.v_out, em, ev);
      end
      step();
    end
    checks++;
    if (bus.output_valid !== 1'b1 || bus.en_acc !== 1'b0 || out_data !== exp) begin
      errors++;
      $display("FAIL output row %0d: ov %b en %b data %0d want 1 0 %0d",
               row, bus.output_valid, bus.en_acc, out_data, exp);
    end
    bus.output_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (bus.output_valid !== 1'b1 || bus.en_acc !== 1'b0 || bus.clear_acc !== 1'b0 ||
          bus.m_out !== 12'sd0 || out_data !== exp) begin
        errors++;
        $display("FAIL backpressure row %0d hold %0d: ov %b en %b clr %b m %0d data %0d want 1 0 0 0 %0d",
                 row, h, bus.output_valid, bus.en_acc, bus.clear_acc, bus.m_out, out_data, exp);
      end
    end
    bus.output_ready = 1'b1;
    step();
    bus.output_ready = 1'b0;
    bus.input_valid  = 1'b0;
    checks++;
    if (bus.output_valid !== 1'b0 ||
        (row == 3 ? bus.input_ready !== 1'b1 : bus.clear_acc !== 1'b1)) begin
      errors++;
      $display("FAIL advance row %0d: ov %b ready %b clr %b", row, bus.output_valid,
               bus.input_ready, bus.clear_acc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.m_out !== 12'sd0 || bus.v_out !== 12'sd0 || bus.clear_acc !== 1'b0 ||
        bus.en_acc !== 1'b0 || bus.output_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: m %0d v %0d clr %b en %b ov %b want all 0",
               bus.m_out, bus.v_out, bus.clear_acc, bus.en_acc, bus.output_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.input_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.input_ready);
    end
  endtask

  task automatic test_load_identity();
    set_identity();
    load(1'b0);
    run_row(0, 12'sd3, 0, 1'b0);
    run_row(1, -12'sd2, 0, 1'b0);
    run_row(2, 12'sd5, 0, 1'b0);
    run_row(3, 12'sd7, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_identity();
    load(1'b0);
    run_row(0, 12'sd3, 10, 1'b0);
    run_row(1, -12'sd2, 0, 1'b0);
    run_row(2, 12'sd5, 3, 1'b0);
    run_row(3, 12'sd7, 0, 1'b0);
  endtask

  task automatic test_stalled_input();
    set_ramp();
    load(1'b1);
    run_row(0, 12'sd30, 0, 1'b0);
    run_row(1, 12'sd70, 0, 1'b0);
    run_row(2, 12'sd110, 0, 1'b0);
    run_row(3, 12'sd150, 0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 16; k++) ref_m[k] = 12'sd2047;
    for (int j = 0; j < 4; j++) ref_v[j] = 12'sd2047;
    load(1'b0);
    for (int r = 0; r < 4; r++) run_row(r, 12'sd2047, 0, 1'b0);
  endtask

  task automatic test_ignore_noise();
    set_ramp();
    load(1'b0);
    run_row(0, 12'sd30, 0, 1'b1);
    run_row(1, 12'sd70, 0, 1'b1);
    run_row(2, 12'sd110, 0, 1'b1);
    run_row(3, 12'sd150, 0, 1'b1);
  endtask

  task automatic test_midrun_reset();
    set_identity();
    load(1'b0);
    run_row(0, 12'sd3, 0, 1'b0);
    step();
    step();
    step();
    checks++;
    if (bus.en_acc !== 1'b1 || bus.v_out !== 12'sd5 || bus.m_out !== 12'sd0) begin
      errors++;
      $display("FAIL midrun_pre: en %b m %0d v %0d want 1 0 5", bus.en_acc, bus.m_out, bus.v_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.en_acc !== 1'b0 || bus.output_valid !== 1'b0 || bus.m_out !== 12'sd0 ||
        bus.v_out !== 12'sd0 || bus.clear_acc !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: en %b ov %b m %0d v %0d clr %b want all 0",
               bus.en_acc, bus.output_valid, bus.m_out, bus.v_out, bus.clear_acc);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.input_ready !== 1'b1 || bus.en_acc !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: ready %b en %b want 1 0", bus.input_ready, bus.en_acc);
    end
  endtask

  task automatic test_back_to_back();
    set_ramp();
    load(1'b1);
    for (int r = 0; r < 4; r++) run_row(r, 12'(30 + 40 * r), 0, 1'b0);
    set_identity();
    load(1'b0);
    run_row(0, 12'sd3, 0, 1'b0);
    run_row(1, -12'sd2, 0, 1'b0);
    run_row(2, 12'sd5, 0, 1'b0);
    run_row(3, 12'sd7, 0, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.input_data   = '0;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;
    test_reset();
    test_load_identity();
    test_backpressure();
    test_stalled_input();
    test_saturation();
    test_ignore_noise();
    test_midrun_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
